button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Conditions the raw game buttons before they reach the game FSM's `btn` input.
- Per button: synchronizes the asynchronous pin, applies optional polarity inversion, and debounces against a millisecond time base derived from `ticks_per_milli`.
- Produces a clean level per button, single-cycle press/release events, and a one-hot view the game FSM consumes directly.

Parameters:
- NUM_BTN, 4, number of buttons.
- DEBOUNCE_MS, 20, number of consecutive millisecond ticks a new input value must hold before it is accepted. Range 1..255.
- SYNC_STAGES, 2, flip-flops in each input synchronizer chain. Minimum 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- ticks_per_milli  input  16  clk cycles per millisecond; 0 is treated as 1.
- btn_raw  input  NUM_BTN  asynchronous button pins.
- btn_invert  input  1  1 = pins are active-low; inversion is applied before the synchronizer.
- btn_level  output  NUM_BTN  debounced, registered button state; 1 = pressed.
- btn_press  output  NUM_BTN  1-cycle pulse on the debounced rising edge.
- btn_release  output  NUM_BTN  1-cycle pulse on the debounced falling edge.
- btn_onehot  output  NUM_BTN  equals btn_level when exactly one bit is set, else 0.
- any_pressed  output  1  OR-reduction of btn_level.
- ms_tick  output  1  1-cycle pulse each millisecond; exported for neighbouring blocks.

Behaviour:
- Reset:
  - All outputs are 0.
  - Synchronizer chains, debounce counters and the tick counter are 0.
  - rst asserted mid-debounce discards the count; no press/release pulse is emitted in the reset cycle or the cycle after.
- Tick generator:
  - 16-bit counter increments each cycle.
  - When it equals max(ticks_per_milli,1)-1: it clears to 0 and ms_tick=1 for that cycle (registered).
  - ticks_per_milli is sampled every cycle. If it changes and the counter is already ≥ the new limit, the counter wraps naturally through 0xFFFF. No protection is required, but the behaviour must not lock up.
- Synchronizer:
  - s = btn_raw ^ {NUM_BTN{btn_invert}} feeds a SYNC_STAGES-deep chain.
  - The last stage is `sync[i]`.
- Debounce, per button i:
  - 8-bit cnt[i].
  - If sync[i] == btn_level[i]: cnt[i] <= 0.
  - Else, on an ms_tick cycle: if cnt[i] == DEBOUNCE_MS-1, then btn_level[i] <= sync[i] and cnt[i] <= 0; otherwise cnt[i] <= cnt[i]+1.
  - Else, with no tick: cnt[i] holds.
  - Any single-cycle return to agreement restarts the count, so bounces are rejected.
- Events:
  - btn_press[i] is registered in the same edge that sets btn_level[i] to 1, i.e. high in the first cycle btn_level[i] is high.
  - btn_release[i] behaves the same way for the falling edge.
  - Simultaneous events on different buttons are reported independently in the same cycle.
- Combinational outputs:
  - btn_onehot is combinational from btn_level: `(btn_level != 0 && (btn_level & (btn_level-1)) == 0) ? btn_level : 0`.
  - any_pressed is combinational from btn_level.
- Latency (raw edge to btn_level):
  - SYNC_STAGES cycles, plus the time to the DEBOUNCE_MS-th ms_tick after the mismatch appears.
  - Bounds: from SYNC_STAGES + (DEBOUNCE_MS-1)*T + 1 to SYNC_STAGES + DEBOUNCE_MS*T cycles, where T = max(ticks_per_milli,1).
- btn_invert toggling while idle:
  - Treated as an input change and debounced normally.
  - It is a static strap in practice.

Decomposition:
- Package `button_pkg`:
  - Defaults for DEBOUNCE_MS and SYNC_STAGES.
  - The onehot-check function.
- One sub-module, `ms_tick_gen`: clk, rst, ticks_per_milli, tick. It is reusable by the score and tone blocks.
- The per-button synchronizer + debounce slice is a generate loop inside `button_conditioner`, not a separate module.

Test Plan:
- Clean press: ticks_per_milli=4, DEBOUNCE_MS=3, btn_raw[0] 0→1 and held 40 cycles.
  - btn_level[0] rises between 11 and 14 cycles after the edge.
  - btn_press[0] is high exactly 1 cycle.
  - btn_onehot=4'b0001, any_pressed=1.
  - Release mirrors this with btn_release[0].
- Bounce rejection: same config, btn_raw[1] toggles every 2 cycles for 30 cycles, then settles at 0.
  - btn_level[1], btn_press[1] and btn_release[1] stay 0 throughout.
- Two buttons: btn_raw=4'b0101 held 40 cycles.
  - btn_level=4'b0101.
  - btn_press[0] and btn_press[2] pulse in the same cycle.
  - btn_onehot=0, any_pressed=1.
- Active-low idle: btn_invert=1, btn_raw=4'b1111 from reset for 50 cycles → all outputs remain 0. Then driving btn_raw=4'b0111 → btn_level=4'b1000.
- Reset mid-debounce: start a press; assert rst for 1 cycle at 8 cycles after the edge; keep btn_raw[3]=1.
  - Outputs are 0 the cycle after rst.
  - btn_level[3] rises a full debounce window later, with no early pulse.
- Tick edge cases:
  - ticks_per_milli=0: ms_tick is high every cycle, and a press with DEBOUNCE_MS=3 is accepted in 2+3 cycles.
  - ticks_per_milli=50: ms_tick period is exactly 50 cycles.

Source files
------------

// File: rtl/button_pkg.sv
// Shared defaults and helpers for the button conditioning and neighbouring
// timing blocks.
package button_pkg;

    localparam int DEBOUNCE_MS_DEFAULT = 20;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond time base: a registered one-cycle pulse every
// max(ticks_per_milli,1) clock cycles.
module ms_tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    output logic        tick
);

    logic [15:0] cnt_q, cnt_d;
    logic [15:0] limit;
    logic        tick_q, tick_d;

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        limit  = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
        tick_d = (cnt_q == limit);
        cnt_d  = tick_d ? 16'd0 : cnt_q + 16'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 16'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes, optionally inverts and debounces the raw game buttons, and
// derives press/release pulses and a one-hot view for the game FSM.
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        ticks_per_milli,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               btn_invert,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_onehot,
    output logic               any_pressed,
    output logic               ms_tick
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_MS - 1);

    ms_tick_gen u_ms_tick_gen (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (ticks_per_milli),
        .tick            (ms_tick)
    );

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [7:0]             cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   press_q, press_d;
        logic                   release_q, release_d;
        logic                   sync_bit;

        // Inversion happens ahead of the first flop; the MSB is the last stage.
        always_comb begin
            sync_d    = {sync_q[SYNC_STAGES-2:0], btn_raw[i] ^ btn_invert};
            sync_bit  = sync_q[SYNC_STAGES-1];
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (sync_bit == level_q) begin
                cnt_d = 8'd0;
            end else if (ms_tick) begin
                if (cnt_q == CNT_LAST) begin
                    level_d   = sync_bit;
                    cnt_d     = 8'd0;
                    press_d   = sync_bit;
                    release_d = ~sync_bit;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end

        // NOTE: these are flop banks, not memories, so they are all cleared
        // by reset; a mid-debounce reset must discard the partial count.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q    <= '0;
                cnt_q     <= 8'd0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync_q    <= sync_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

    assign btn_onehot  = is_onehot(32'(btn_level)) ? btn_level : '0;
    assign any_pressed = |btn_level;

endmodule
